// File: rtl/ifu_fetch_pkg.sv
// Shared fetch definitions: sequential PC step, reset PC, fault codes and FSM encoding.
package ifu_fetch_pkg;

  localparam int unsigned INST_LENTH         = 4;
  localparam logic [31:0] PC_INITIAL_ADDRESS = 32'h8000_0000;

  localparam logic [1:0] FETCH_FAULT_NONE     = 2'd0;
  localparam logic [1:0] FETCH_FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FETCH_FAULT_ACCESS   = 2'd2;
  localparam logic [1:0] FETCH_FAULT_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_REQ   = 3'd1,
    FETCH_WAIT  = 3'd2,
    FETCH_HOLD  = 3'd3,
    FETCH_DRAIN = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch: one imem read per accepted PC, result held for decode,
// with misalign/access/timeout faults and discard of responses from flushed fetches.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INST_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              pc_ready_o,
  input  logic              flush_i,
  output logic              imem_req_valid_o,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_req_ready_i,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rsp_data_i,
  input  logic              imem_rsp_err_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic [1:0]        inst_fault_o,
  input  logic              inst_ready_i
);

  localparam int unsigned TMR_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  fetch_state_e      state_q, state_d;
  logic              stale_q, stale_d;
  logic              pend_flush_q, pend_flush_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              inst_valid_q, inst_valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [1:0]        fault_q, fault_d;

  assign pc_ready_o       = (state_q == FETCH_IDLE) && !stale_q && !flush_i;
  assign imem_req_valid_o = req_valid_q;
  assign imem_req_addr_o  = req_addr_q;
  assign inst_valid_o     = inst_valid_q;
  assign inst_o           = inst_q;
  assign inst_pc_o        = inst_pc_q;
  assign inst_fault_o     = fault_q;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FETCH_IDLE;
      stale_q      <= 1'b0;
      pend_flush_q <= 1'b0;
      timer_q      <= '0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      fault_q      <= FETCH_FAULT_NONE;
    end else begin
      state_q      <= state_d;
      stale_q      <= stale_d;
      pend_flush_q <= pend_flush_d;
      timer_q      <= timer_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      fault_q      <= fault_d;
    end
  end

  // Next state; flush outranks every other event
  always_comb begin
    state_d      = state_q;
    stale_d      = stale_q;
    pend_flush_d = pend_flush_q;
    timer_d      = timer_q;
    req_valid_d  = req_valid_q;
    req_addr_d   = req_addr_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    fault_d      = fault_q;

    // A late response from a timed-out fetch is swallowed outside WAIT/DRAIN
    if (stale_q && imem_rsp_valid_i &&
        (state_q != FETCH_WAIT) && (state_q != FETCH_DRAIN)) begin
      stale_d = 1'b0;
    end

    case (state_q)
      FETCH_IDLE: begin
        if (pc_valid_i && pc_ready_o) begin
          inst_pc_d = pc_i;
          if (pc_i[1:0] != 2'b00) begin
            state_d      = FETCH_HOLD;
            inst_valid_d = 1'b1;
            inst_d       = '0;
            fault_d      = FETCH_FAULT_MISALIGN;
          end else begin
            state_d     = FETCH_REQ;
            req_valid_d = 1'b1;
            req_addr_d  = pc_i;
          end
        end
      end
      FETCH_REQ: begin
        if (flush_i) pend_flush_d = 1'b1;
        if (imem_req_ready_i) begin
          req_valid_d = 1'b0;
          timer_d     = '0;
          if (flush_i || pend_flush_q) begin
            state_d      = FETCH_DRAIN;
            pend_flush_d = 1'b0;
          end else begin
            state_d = FETCH_WAIT;
          end
        end
      end
      FETCH_WAIT: begin
        if (flush_i) begin
          state_d = imem_rsp_valid_i ? FETCH_IDLE : FETCH_DRAIN;
        end else if (imem_rsp_valid_i) begin
          state_d      = FETCH_HOLD;
          inst_valid_d = 1'b1;
          inst_d       = imem_rsp_err_i ? '0 : imem_rsp_data_i;
          fault_d      = imem_rsp_err_i ? FETCH_FAULT_ACCESS : FETCH_FAULT_NONE;
        end else if (timer_q == TMR_LAST) begin
          state_d      = FETCH_HOLD;
          inst_valid_d = 1'b1;
          inst_d       = '0;
          fault_d      = FETCH_FAULT_TIMEOUT;
          stale_d      = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      FETCH_HOLD: begin
        if (flush_i || inst_ready_i) begin
          state_d      = FETCH_IDLE;
          inst_valid_d = 1'b0;
        end
      end
      FETCH_DRAIN: begin
        if (imem_rsp_valid_i) state_d = FETCH_IDLE;
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

endmodule
